// File: rtl/product_drain_pkg.sv
// Shared types and dimensions for the product drain path.
package product_drain_pkg;

   localparam int DIM_C     = 4;
   localparam int DIM_A     = 4;
   localparam int ACC_WIDTH = 16;

   // Row index width; a single-row array still needs a one-bit index.
   function automatic int row_w(input int dim_c);
      return (dim_c > 1) ? $clog2(dim_c) : 1;
   endfunction

   typedef logic [DIM_A-1:0][ACC_WIDTH-1:0] prod_row_t;
   typedef prod_row_t [DIM_C-1:0]           prod_arr_t;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } drain_state_e;

endpackage

// File: rtl/product_drain_buffer.sv
// Holding register for one full product array with a row-select read port.
module product_drain_buffer
   import product_drain_pkg::*;
#(
   parameter int DIM_C     = product_drain_pkg::DIM_C,
   parameter int DIM_A     = product_drain_pkg::DIM_A,
   parameter int ACC_WIDTH = product_drain_pkg::ACC_WIDTH,
   parameter int ROW_W     = row_w(DIM_C)
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    capture,
   input  logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] load_data,
   input  logic [ROW_W-1:0]                        row_sel,
   output logic [DIM_A-1:0][ACC_WIDTH-1:0]         row_data
);

   logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] buf_q;

   // Array register: cleared on reset, loaded whole on a capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q <= '0;
      end else if (capture) begin
         buf_q <= load_data;
      end
   end

   // Row read mux; an index beyond the array reads as zero.
   always_comb begin
      row_data = '0;
      for (int i = 0; i < DIM_C; i++) begin
         if (row_sel == ROW_W'(i)) begin
            row_data = buf_q[i];
         end
      end
   end

endmodule

// File: rtl/product_drain.sv
// Product array drain: accepts a whole array, streams it out row by row.
//
// state | meaning
// IDLE  | no array held; ready to accept a load
// DRAIN | array held; presenting row row_q on the output
module product_drain
   import product_drain_pkg::*;
#(
   parameter  int DIM_C     = product_drain_pkg::DIM_C,
   parameter  int DIM_A     = product_drain_pkg::DIM_A,
   parameter  int ACC_WIDTH = product_drain_pkg::ACC_WIDTH,
   localparam int ROW_W     = row_w(DIM_C)
) (
   input  logic                                        clk,
   input  logic                                        rst_n,
   input  logic                                        load_valid,
   output logic                                        load_ready,
   input  logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0]  load_data,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [DIM_A-1:0][ACC_WIDTH-1:0]             out_data,
   output logic [ROW_W-1:0]                            out_row,
   output logic                                        out_last,
   output logic                                        busy
);

   drain_state_e state_q, state_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic capture;
   logic is_last;
   logic [DIM_A-1:0][ACC_WIDTH-1:0] row_data;

   product_drain_buffer #(
      .DIM_C     (DIM_C),
      .DIM_A     (DIM_A),
      .ACC_WIDTH (ACC_WIDTH),
      .ROW_W     (ROW_W)
   ) u_buffer (
      .clk       (clk),
      .rst_n     (rst_n),
      .capture   (capture),
      .load_data (load_data),
      .row_sel   (row_q),
      .row_data  (row_data)
   );

   // State and row counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
      end
   end

   // Next state, row advance, handshakes and output presentation.
   // load_ready depends on out_ready combinationally so a new array can be
   // taken on the accepted last beat without a bubble.
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      is_last    = (row_q == ROW_W'(DIM_C - 1));
      busy       = (state_q == DRAIN);
      out_valid  = (state_q == DRAIN);
      out_last   = (state_q == DRAIN) && is_last;
      out_row    = row_q;
      out_data   = (state_q == DRAIN) ? row_data : '0;
      load_ready = (state_q == IDLE) || ((state_q == DRAIN) && out_ready && is_last);
      capture    = load_valid && load_ready;

      case (state_q)
         IDLE: begin
            if (capture) begin
               row_d   = '0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (out_ready) begin
               if (is_last) begin
                  row_d   = '0;
                  state_d = load_valid ? DRAIN : IDLE;
               end else begin
                  row_d = row_q + ROW_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            row_d   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_product_drain.sv
// Directed bench for product_drain with DIM_C=4, DIM_A=4, ACC_WIDTH=16.
module tb_product_drain;
   import product_drain_pkg::*;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            load_valid;
   logic            load_ready;
   prod_arr_t       load_data;
   logic            out_valid;
   logic            out_ready;
   prod_row_t       out_data;
   logic [1:0]      out_row;
   logic            out_last;
   logic            busy;

   int vectors    = 0;
   int miscompares = 0;

   prod_arr_t arr_a, arr_b, arr_c;

   always #5 clk = ~clk;

   product_drain dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_row    (out_row),
      .out_last   (out_last),
      .busy       (busy)
   );

   function automatic prod_arr_t make_arr(input int base);
      prod_arr_t a;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            a[i][j] = 16'(base + i * 16 + j);
      return a;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      vectors++;
      assert (obs === exp_v)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Check a presented row at the current sample point.
   task automatic chk_row(input string tag, input prod_arr_t a, input int r);
      chk({tag, " valid"}, 64'(out_valid), 64'(1));
      chk({tag, " busy"},  64'(busy),      64'(1));
      chk({tag, " row"},   64'(out_row),   64'(r));
      chk({tag, " last"},  64'(out_last),  64'(r == 3));
      chk({tag, " data"},  out_data,       a[r]);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " valid"},  64'(out_valid),  64'(0));
      chk({tag, " busy"},   64'(busy),       64'(0));
      chk({tag, " lready"}, 64'(load_ready), 64'(1));
   endtask

   initial begin
      arr_a = make_arr(0);
      arr_b = make_arr(16'hA000);
      arr_c = make_arr(16'h5500);

      rst_n      = 1'b0;
      load_valid = 1'b1;
      out_ready  = 1'b1;
      load_data  = arr_c;
      #2;
      chk("reset valid",  64'(out_valid),  64'(0));
      chk("reset busy",   64'(busy),       64'(0));
      chk("reset lready", 64'(load_ready), 64'(1));
      chk("reset data",   out_data,        64'(0));
      chk("reset row",    64'(out_row),    64'(0));
      chk("reset last",   64'(out_last),   64'(0));
      load_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Basic drain.
      @(negedge clk);
      load_data  = arr_a;
      load_valid = 1'b1;
      out_ready  = 1'b1;
      #1 chk("t2 lready", 64'(load_ready), 64'(1));
      @(negedge clk);
      load_valid = 1'b0;
      load_data  = arr_c;
      for (int r = 0; r < 4; r++) begin
         #1 chk_row("t2", arr_a, r);
         if (r == 2) chk("t2 row2 literal", out_data, 64'h0023_0022_0021_0020);
         @(negedge clk);
      end
      #1 chk_idle("t2 end");

      // Backpressure on row 1.
      @(negedge clk);
      load_data  = arr_a;
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      load_data  = arr_c;
      #1 chk_row("t3 r0", arr_a, 0);
      @(negedge clk);
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1 chk_row("t3 hold", arr_a, 1);
         chk("t3 hold lready", 64'(load_ready), 64'(0));
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1 chk_row("t3 r1", arr_a, 1);
      @(negedge clk);
      #1 chk_row("t3 r2", arr_a, 2);
      @(negedge clk);
      #1 chk_row("t3 r3", arr_a, 3);
      @(negedge clk);
      #1 chk_idle("t3 end");

      // Back-to-back loads with no bubble.
      @(negedge clk);
      load_data  = arr_a;
      load_valid = 1'b1;
      @(negedge clk);
      load_data = arr_b;
      for (int r = 0; r < 4; r++) begin
         #1 chk_row("t4 a", arr_a, r);
         chk("t4 lready", 64'(load_ready), 64'(r == 3));
         @(negedge clk);
      end
      load_valid = 1'b0;
      load_data  = arr_c;
      for (int r = 0; r < 4; r++) begin
         #1 chk_row("t4 b", arr_b, r);
         @(negedge clk);
      end
      #1 chk_idle("t4 end");

      // Load attempt while busy is ignored.
      @(negedge clk);
      load_data  = arr_a;
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      #1 chk_row("t5 r0", arr_a, 0);
      @(negedge clk);
      out_ready  = 1'b0;
      load_valid = 1'b1;
      load_data  = arr_c;
      #1 chk("t5 lready", 64'(load_ready), 64'(0));
      chk_row("t5 r1", arr_a, 1);
      @(negedge clk);
      load_valid = 1'b0;
      #1 chk_row("t5 r1 after", arr_a, 1);
      out_ready = 1'b1;
      @(negedge clk);
      #1 chk_row("t5 r2", arr_a, 2);
      @(negedge clk);
      #1 chk_row("t5 r3", arr_a, 3);
      @(negedge clk);
      #1 chk_idle("t5 end");

      // Reset during row 2 aborts the drain.
      @(negedge clk);
      load_data  = arr_b;
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      #1 chk_row("t6 r0", arr_b, 0);
      @(negedge clk);
      #1 chk_row("t6 r1", arr_b, 1);
      @(negedge clk);
      out_ready = 1'b0;
      #1 chk_row("t6 r2", arr_b, 2);
      #1 rst_n = 1'b0;
      load_valid = 1'b1;
      #1;
      chk("t6 rst valid",  64'(out_valid),  64'(0));
      chk("t6 rst busy",   64'(busy),       64'(0));
      chk("t6 rst lready", 64'(load_ready), 64'(1));
      chk("t6 rst data",   out_data,        64'(0));
      chk("t6 rst row",    64'(out_row),    64'(0));
      chk("t6 rst last",   64'(out_last),   64'(0));
      @(negedge clk);
      load_valid = 1'b0;
      rst_n      = 1'b1;
      #1 chk_idle("t6 post");
      @(negedge clk);
      load_data  = arr_c;
      load_valid = 1'b1;
      out_ready  = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      for (int r = 0; r < 4; r++) begin
         #1 chk_row("t6 c", arr_c, r);
         @(negedge clk);
      end
      #1 chk_idle("t6 end");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
